// File: rtl/mst_fifo_slv.sv
// FIFO-bus slave (245 mode, single channel) with host-side valid/ready streams on both FIFOs.
// Optional statistics counters are enabled by defining MST_FIFO_SLV_STAT_EN.
module mst_fifo_slv #(
    parameter int unsigned AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_n,
    input  logic        rd_n,
    input  logic        oe_n,
    input  logic [31:0] idata,
    input  logic [3:0]  ibe,
    output logic        rxf_n,
    output logic        txe_n,
    output logic [31:0] odata,
    output logic [3:0]  obe,
    output logic        dt_oe,
    input  logic        hin_vld,
    input  logic [35:0] hin_dat,
    output logic        hin_rdy,
    output logic        hout_vld,
    output logic [35:0] hout_dat,
    input  logic        hout_rdy,
    output logic        proto_err,
    output logic [15:0] wr_cnt,
    output logic [15:0] rd_cnt
);

    localparam int unsigned Depth = 2 ** AW;

    typedef logic [AW:0] ptr_t;

    typedef enum logic [1:0] {
        StIdle,
        StRdTa,
        StRdAct,
        StWrAct
    } state_e;

    state_e state_q, state_d;

    logic [35:0] rx_mem [Depth];
    logic [35:0] tx_mem [Depth];

    ptr_t rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    ptr_t tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;

    logic rxf_n_q, txe_n_q, hin_rdy_q, hout_vld_q, dt_oe_q, err_q;
    logic rx_empty_d, rx_full_d, tx_empty_d, tx_full_d;

    logic rd_strobe, wr_strobe, in_read, err_now;
    logic rx_push, rx_pop, tx_push, tx_pop;

    always_comb begin
        // Strobes presented while the matching flag is high are simply ignored.
        rd_strobe = !rd_n && !rxf_n_q;
        wr_strobe = !wr_n && !txe_n_q;
        in_read   = (state_q == StRdTa) || (state_q == StRdAct);
        err_now   = (rd_strobe && oe_n) ||
                    (wr_strobe && !oe_n) ||
                    (wr_strobe && in_read) ||
                    (!oe_n && (state_q == StWrAct));

        rx_push = hin_vld && hin_rdy_q;
        rx_pop  = rd_strobe && (state_q == StRdAct) && !err_now;
        tx_push = wr_strobe && !err_now;
        tx_pop  = hout_vld_q && hout_rdy;

        rx_wp_d = rx_wp_q + {{AW{1'b0}}, rx_push};
        rx_rp_d = rx_rp_q + {{AW{1'b0}}, rx_pop};
        tx_wp_d = tx_wp_q + {{AW{1'b0}}, tx_push};
        tx_rp_d = tx_rp_q + {{AW{1'b0}}, tx_pop};

        rx_empty_d = (rx_wp_d == rx_rp_d);
        rx_full_d  = (rx_wp_d[AW] != rx_rp_d[AW]) && (rx_wp_d[AW-1:0] == rx_rp_d[AW-1:0]);
        tx_empty_d = (tx_wp_d == tx_rp_d);
        tx_full_d  = (tx_wp_d[AW] != tx_rp_d[AW]) && (tx_wp_d[AW-1:0] == tx_rp_d[AW-1:0]);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!oe_n) begin
                    state_d = StRdTa;
                end else if (wr_strobe) begin
                    state_d = StWrAct;
                end
            end
            StRdTa:  state_d = oe_n ? StIdle : StRdAct;
            StRdAct: if (oe_n) state_d = StIdle;
            StWrAct: if (wr_n) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rxf_n_q    <= 1'b1;
            txe_n_q    <= 1'b1;
            hin_rdy_q  <= 1'b0;
            hout_vld_q <= 1'b0;
            dt_oe_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            rxf_n_q    <= rx_empty_d;
            txe_n_q    <= tx_full_d;
            hin_rdy_q  <= !rx_full_d;
            hout_vld_q <= !tx_empty_d;
            dt_oe_q    <= !oe_n;
            err_q      <= err_q || err_now;
        end
    end

    // Storage needs no reset: pointers alone define the contents.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= hin_dat;
        if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= {ibe, idata};
    end

    assign {obe, odata} = rx_mem[rx_rp_q[AW-1:0]];
    assign hout_dat     = tx_mem[tx_rp_q[AW-1:0]];
    assign rxf_n        = rxf_n_q;
    assign txe_n        = txe_n_q;
    assign hin_rdy      = hin_rdy_q;
    assign hout_vld     = hout_vld_q;
    assign dt_oe        = dt_oe_q;
    assign proto_err    = err_q;

`ifdef MST_FIFO_SLV_STAT_EN
    logic [15:0] wr_cnt_q, rd_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_q + {15'd0, tx_push};
            rd_cnt_q <= rd_cnt_q + {15'd0, rx_pop};
        end
    end

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;
`else
    assign wr_cnt = 16'h0;
    assign rd_cnt = 16'h0;
`endif

endmodule
